da_mac_engine: RTL and testbench
================================

Name: da_mac_engine

Overview:
- Distributed-arithmetic (DA) multiply-accumulate core for a FIR filter.
- Eight coefficient look-up banks, each 256 × 20-bit signed, hold precomputed partial sums. The banks are loaded through a write port before filtering starts.
- Each start pulse carries one bit-slice step. The eight 8-bit slice addresses A7..A0 select one word per bank; the eight words are summed, then shift-accumulated MSB-first over 16 steps into a 39-bit result.

Parameters:
- CW, 20, coefficient word width (signed)
- AW, 8, address width per bank (256 entries)
- NBANK, 8, number of banks; CADDR width is AW+3 = 11
- STEPS, 16, bit-slice steps per output
- ACCW, 39, accumulator/output width; equals CW+3+STEPS

Ports:
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-high
- CIN, in, 20, signed coefficient write data
- CADDR, in, 11, write address: [10:8] selects bank, [7:0] selects entry
- CLOAD, in, 1, coefficient write enable
- valid_in, in, 1, qualifies CLOAD; a write needs both high
- start, in, 1, launches one DA step using A7..A0 sampled this cycle
- A7..A0, in, 8 each, unsigned slice address for bank 7..0
- ACC_OUT, out, 39, signed filter result
- valid_out, out, 1, one-cycle pulse when ACC_OUT updates

Behaviour:
- Reset (async assert, sync release):
  - ACC_OUT=0, valid_out=0.
  - Step counter, accumulator and all pipeline valid bits cleared.
  - Bank contents are not reset. Reading an unwritten entry returns an undefined value, so software loads every used entry first.
- Coefficient write: at a rising edge with CLOAD && valid_in, bank[CADDR[10:8]][CADDR[7:0]] <= CIN. One write per cycle.
- Step pipeline. With start high at edge t:
  - t: A7..A0 registered.
  - t+1: the eight bank words are read into registers.
  - t+2: 4 pairwise sums (21b).
  - t+3: 2 sums (22b).
  - t+4: final sum S (23b signed).
  - t+5: the accumulate stage acts on S.
- Accumulate stage:
  - When step counter = 0: acc <= sign-extended S.
  - Otherwise: acc <= (acc <<< 1) + S.
  - Arithmetic is signed two's-complement at 39 bits. No overflow is possible within 16 steps.
  - The counter increments each accepted step and wraps 15→0.
- Completion: on the 16th step (counter = 15) the new acc value goes to ACC_OUT and valid_out=1 for exactly that one cycle. ACC_OUT then holds until the next completion. The next step starts a fresh accumulation with no explicit clear.
- Throughput: start may be asserted every cycle, fully pipelined. Cycles with start low insert bubbles and do not affect the counter.
- The bank address slices are unsigned; the first step corresponds to the MSB slice. No sign-bit subtraction is performed; signed behaviour comes from the coefficient contents.
- Simultaneous write and read of the same entry in one cycle: the read returns the old value.
- Writes while steps are in flight are legal and take effect for reads issued after the write edge.
- Reset mid-frame discards the partial accumulation and any in-flight steps. The next accepted start is step 0.

Decomposition:
- Shared package da_pkg: CW, AW, NBANK, STEPS, ACCW constants; typedefs coeff_t (signed [19:0]), addr_t ([7:0]), acc_t (signed [38:0]).
- One natural sub-module, da_coeff_bank: an 8 × 256 × CW storage array with one write port and eight registered read ports.
- The adder tree and accumulator stay in the top module.

Test Plan:
- Unit weight: all entries 0 except bank0[1]=1. Then 16 starts with A0=1 and others 0 → ACC_OUT=65535, valid_out high one cycle, 5 cycles after the 16th start.
- Negative sum: all banks [255]=-1. Then 16 starts with all A=255 → S=-8 per step, ACC_OUT = -8×65535 = -524280.
- Weighting check: bank3[7]=5, all else 0. A3=7 on the first step only, all A=0 on the other 15 → ACC_OUT = 5×2^15 = 163840. Repeat with A3=7 on the last step only → 5.
- Back-to-back frames: 32 consecutive starts using the unit-weight setup, the second frame with A0=0 throughout → outputs 65535 then 0, two valid_out pulses 16 cycles apart, no clear needed.
- Reset mid-frame: assert reset after 7 steps, release, then run 16 unit-weight steps → ACC_OUT=65535. ACC_OUT reads 0 between reset and that completion.
- Write/read collision: bank0[1]=1. Write bank0[1]=9 in the same cycle the step's read occurs → that step uses 1. The following step uses 9.

Source files
------------

// File: rtl/da_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
// Shared constants and types for the distributed-arithmetic MAC engine.
//   CW    : coefficient (partial-sum) word width, signed
//   AW    : address width of one coefficient bank
//   NBANK : number of coefficient banks
//   STEPS : bit-slice steps per filter output
//   ACCW  : accumulator / result width (CW + 3 + STEPS)
// -----------------------------------------------------------------------------
package da_pkg;

  localparam int CW    = 20;
  localparam int AW    = 8;
  localparam int NBANK = 8;
  localparam int STEPS = 16;
  localparam int ACCW  = 39;

  localparam int BW    = $clog2(NBANK);   // bank-select width
  localparam int CAW   = AW + BW;         // coefficient write address width
  localparam int CNTW  = $clog2(STEPS);   // step counter width

  // Adder-tree widths: each level adds one bit of headroom.
  localparam int S1W   = CW + 1;
  localparam int S2W   = CW + 2;
  localparam int SW    = CW + 3;

  typedef logic signed [CW-1:0]   coeff_t;
  typedef logic        [AW-1:0]   addr_t;
  typedef logic signed [ACCW-1:0] acc_t;
  typedef logic        [BW-1:0]   bank_sel_t;
  typedef logic        [CNTW-1:0] cnt_t;

  // Sign-extend the final tree sum to accumulator width.
  function automatic acc_t sext_sum(input logic signed [SW-1:0] s);
    return {{(ACCW-SW){s[SW-1]}}, s};
  endfunction

endpackage

// File: rtl/da_coeff_bank.sv
// -----------------------------------------------------------------------------
// da_coeff_bank
// NBANK x 2^AW x CW coefficient storage with one write port and NBANK
// registered read ports (one per bank). A read and a write to the same entry
// on the same edge returns the old contents.
//   clk      : clock, rising edge
//   we_i     : write enable
//   wbank_i  : bank selected for the write
//   waddr_i  : entry within the selected bank
//   wdata_i  : signed write data
//   raddr_i  : per-bank read address
//   rdata_o  : per-bank registered read data
// -----------------------------------------------------------------------------
module da_coeff_bank
  import da_pkg::*;
(
  input  logic      clk,
  input  logic      we_i,
  input  bank_sel_t wbank_i,
  input  addr_t     waddr_i,
  input  coeff_t    wdata_i,
  input  addr_t     raddr_i [NBANK],
  output coeff_t    rdata_o [NBANK]
);

  coeff_t mem_q [NBANK][1<<AW];

  // NOTE: storage and its read registers are deliberately not reset, so the
  // array maps onto RAM; software loads every used entry before filtering.
  // NOTE: non-blocking assignments make every read sample the pre-edge
  // contents, which gives read-old-data on a same-entry collision.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      rdata_o[b] <= mem_q[b][raddr_i[b]];
    end
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/da_mac_engine.sv
// -----------------------------------------------------------------------------
// da_mac_engine
// Distributed-arithmetic MAC core for a FIR filter. Each start pulse carries
// one bit-slice step (MSB slice first): the eight slice addresses pick one
// precomputed partial sum per bank, the words are summed in a 3-level tree and
// shift-accumulated over STEPS steps into a signed ACCW-bit result.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   CIN       : signed coefficient write data
//   CADDR     : write address, [10:8] bank, [7:0] entry
//   CLOAD     : coefficient write enable (qualified by valid_in)
//   valid_in  : qualifies CLOAD
//   start     : launches one DA step with A7..A0 sampled this cycle
//   A7..A0    : unsigned slice address per bank
//   ACC_OUT   : signed filter result, holds between completions
//   valid_out : one-cycle pulse when ACC_OUT updates
// Latency: start at edge t -> result registered at edge t+5.
// -----------------------------------------------------------------------------
module da_mac_engine
  import da_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [CW-1:0]   CIN,
  input  logic        [CAW-1:0]  CADDR,
  input  logic                   CLOAD,
  input  logic                   valid_in,
  input  logic                   start,
  input  logic        [AW-1:0]   A7,
  input  logic        [AW-1:0]   A6,
  input  logic        [AW-1:0]   A5,
  input  logic        [AW-1:0]   A4,
  input  logic        [AW-1:0]   A3,
  input  logic        [AW-1:0]   A2,
  input  logic        [AW-1:0]   A1,
  input  logic        [AW-1:0]   A0,
  output logic signed [ACCW-1:0] ACC_OUT,
  output logic                   valid_out
);

  // Stage valid bits: address reg, bank read, tree levels 1..3.
  logic v_a_q, v_r_q, v_s1_q, v_s2_q, v_s3_q;

  addr_t                 a_q  [NBANK];
  coeff_t                rd   [NBANK];
  logic signed [S1W-1:0] s1_q [4];
  logic signed [S2W-1:0] s2_q [2];
  logic signed [SW-1:0]  s3_q;

  acc_t acc_q, acc_d;
  acc_t acc_out_q;
  logic valid_out_q;
  cnt_t cnt_q, cnt_d;
  logic frame_done;

  // ---------------------------------------------------------------------------
  // Coefficient storage
  // ---------------------------------------------------------------------------
  da_coeff_bank u_bank (
    .clk     (clk),
    .we_i    (CLOAD & valid_in),
    .wbank_i (CADDR[CAW-1:AW]),
    .waddr_i (CADDR[AW-1:0]),
    .wdata_i (CIN),
    .raddr_i (a_q),
    .rdata_o (rd)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers. Only the valid bits carry meaning across reset, so the
  // data stages run free and need no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    a_q[0] <= A0;
    a_q[1] <= A1;
    a_q[2] <= A2;
    a_q[3] <= A3;
    a_q[4] <= A4;
    a_q[5] <= A5;
    a_q[6] <= A6;
    a_q[7] <= A7;

    for (int i = 0; i < 4; i++) begin
      s1_q[i] <= {rd[2*i][CW-1], rd[2*i]} + {rd[2*i+1][CW-1], rd[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      s2_q[i] <= {s1_q[2*i][S1W-1], s1_q[2*i]} + {s1_q[2*i+1][S1W-1], s1_q[2*i+1]};
    end
    s3_q <= {s2_q[0][S2W-1], s2_q[0]} + {s2_q[1][S2W-1], s2_q[1]};
  end

  // ---------------------------------------------------------------------------
  // Accumulate stage. Step 0 of a frame loads S, later steps double and add,
  // so the first (MSB) slice ends up weighted by 2^(STEPS-1).
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    if (v_s3_q) begin
      if (cnt_q == '0) begin
        acc_d = sext_sum(s3_q);
      end else begin
        acc_d = (acc_q <<< 1) + sext_sum(s3_q);
      end
      if (cnt_q == cnt_t'(STEPS-1)) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_a_q       <= 1'b0;
      v_r_q       <= 1'b0;
      v_s1_q      <= 1'b0;
      v_s2_q      <= 1'b0;
      v_s3_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      v_a_q       <= start;
      v_r_q       <= v_a_q;
      v_s1_q      <= v_r_q;
      v_s2_q      <= v_s1_q;
      v_s3_q      <= v_s2_q;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      valid_out_q <= frame_done;
      if (frame_done) begin
        acc_out_q <= acc_d;
      end
    end
  end

  assign ACC_OUT   = acc_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_da_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_da_mac_engine
// Directed bench for da_mac_engine: loads coefficient banks, runs bit-slice
// frames and compares ACC_OUT / valid_out against hand-computed results.
// -----------------------------------------------------------------------------
module tb_da_mac_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [19:0] CIN;
  logic        [10:0] CADDR;
  logic               CLOAD;
  logic               valid_in;
  logic               start;
  logic        [7:0]  A7, A6, A5, A4, A3, A2, A1, A0;
  logic signed [38:0] ACC_OUT;
  logic               valid_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_start_edge = 0;

  // Every cycle valid_out is high, the result and the edge count are logged.
  logic signed [38:0] vo_val [$];
  int                 vo_cyc [$];

  da_mac_engine dut (
    .clk       (clk),
    .reset     (reset),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .valid_in  (valid_in),
    .start     (start),
    .A7        (A7),
    .A6        (A6),
    .A5        (A5),
    .A4        (A4),
    .A3        (A3),
    .A2        (A2),
    .A1        (A1),
    .A0        (A0),
    .ACC_OUT   (ACC_OUT),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      vo_val.push_back(ACC_OUT);
      vo_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_one(input int b, input int e, input int v);
    @(negedge clk);
    CLOAD    = 1'b1;
    valid_in = 1'b1;
    CADDR    = {3'(b), 8'(e)};
    CIN      = 20'(v);
    @(negedge clk);
    CLOAD    = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic clear_banks();
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      CLOAD    = 1'b1;
      valid_in = 1'b1;
      CADDR    = 11'(i);
      CIN      = '0;
    end
    @(negedge clk);
    CLOAD    = 1'b0;
    valid_in = 1'b0;
  endtask

  // One step; optionally a coefficient write on the same edge.
  task automatic send_step(input logic [63:0] a, input logic we,
                           input logic [10:0] ca, input logic signed [19:0] cd);
    @(negedge clk);
    start = 1'b1;
    {A7, A6, A5, A4, A3, A2, A1, A0} = a;
    CLOAD    = we;
    valid_in = we;
    CADDR    = ca;
    CIN      = cd;
    last_start_edge = cyc + 1;
  endtask

  task automatic end_steps();
    @(negedge clk);
    start    = 1'b0;
    CLOAD    = 1'b0;
    valid_in = 1'b0;
    {A7, A6, A5, A4, A3, A2, A1, A0} = '0;
  endtask

  task automatic clear_log();
    vo_val.delete();
    vo_cyc.delete();
  endtask

  // Bounded wait for n pulses, then a short tail to catch extra pulses.
  task automatic wait_pulses(input int n, input string tag);
    for (int i = 0; i < 60 && vo_val.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(tag, vo_val.size(), n);
  endtask

  localparam logic [63:0] UNIT  = 64'h0000_0000_0000_0001;
  localparam logic [63:0] ALLFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] A3_7  = 64'h0000_0000_0700_0000;

  initial begin
    reset = 1'b1;
    start = 1'b0; CLOAD = 1'b0; valid_in = 1'b0;
    CADDR = '0; CIN = '0;
    {A7, A6, A5, A4, A3, A2, A1, A0} = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_acc_out", ACC_OUT, 0);
    check("rst_valid_out", valid_out, 0);
    reset = 1'b0;

    // Unit weight: bank0[1]=1, A0=1 for all steps -> 2^16-1
    clear_banks();
    write_one(0, 1, 1);
    clear_log();
    for (int k = 0; k < 16; k++) send_step(UNIT, 1'b0, '0, '0);
    end_steps();
    wait_pulses(1, "unit_pulse_count");
    check("unit_value", vo_val[0], 65535);
    check("unit_latency", vo_cyc[0], last_start_edge + 5);
    repeat (5) @(negedge clk);
    check("unit_hold", ACC_OUT, 65535);
    check("unit_valid_low", valid_out, 0);

    // Negative sum: all banks [255] = -1 -> S=-8 each step
    for (int b = 0; b < 8; b++) write_one(b, 255, -1);
    clear_log();
    for (int k = 0; k < 16; k++) send_step(ALLFF, 1'b0, '0, '0);
    end_steps();
    wait_pulses(1, "neg_pulse_count");
    check("neg_value", vo_val[0], -524280);

    // Weighting: bank3[7]=5 on first step only, then last step only
    clear_banks();
    write_one(3, 7, 5);
    clear_log();
    for (int k = 0; k < 16; k++) send_step((k == 0) ? A3_7 : 64'h0, 1'b0, '0, '0);
    end_steps();
    wait_pulses(1, "msb_pulse_count");
    check("msb_value", vo_val[0], 163840);
    clear_log();
    for (int k = 0; k < 16; k++) send_step((k == 15) ? A3_7 : 64'h0, 1'b0, '0, '0);
    end_steps();
    wait_pulses(1, "lsb_pulse_count");
    check("lsb_value", vo_val[0], 5);

    // Back-to-back frames, no clear between them
    clear_banks();
    write_one(0, 1, 1);
    clear_log();
    for (int k = 0; k < 32; k++) send_step((k < 16) ? UNIT : 64'h0, 1'b0, '0, '0);
    end_steps();
    wait_pulses(2, "b2b_pulse_count");
    check("b2b_first", vo_val[0], 65535);
    check("b2b_second", vo_val[1], 0);
    check("b2b_spacing", vo_cyc[1] - vo_cyc[0], 16);

    // Reset mid-frame discards partial and in-flight steps
    clear_log();
    for (int k = 0; k < 7; k++) send_step(UNIT, 1'b0, '0, '0);
    @(negedge clk);
    start = 1'b0;
    {A7, A6, A5, A4, A3, A2, A1, A0} = '0;
    reset = 1'b1;
    #1;
    check("midrst_acc_out", ACC_OUT, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_pulse", vo_val.size(), 0);
    for (int k = 0; k < 16; k++) send_step(UNIT, 1'b0, '0, '0);
    end_steps();
    check("midrst_before_done", ACC_OUT, 0);
    wait_pulses(1, "midrst_pulse_count");
    check("midrst_value", vo_val[0], 65535);

    // Collision: step 14 reads bank0[1] on the same edge it is rewritten to 9.
    // Step 14 sees old 1 (weight 2), step 15 sees 9 (weight 1) -> 11.
    clear_log();
    for (int k = 0; k < 15; k++) send_step((k == 14) ? UNIT : 64'h0, 1'b0, '0, '0);
    send_step(UNIT, 1'b1, 11'h001, 20'sd9);
    end_steps();
    wait_pulses(1, "coll_pulse_count");
    check("coll_value", vo_val[0], 11);

    // CLOAD without valid_in must not write: bank0[1] stays 9
    @(negedge clk);
    CLOAD = 1'b1; valid_in = 1'b0; CADDR = 11'h001; CIN = 20'sd100;
    @(negedge clk);
    CLOAD = 1'b0;
    clear_log();
    for (int k = 0; k < 16; k++) send_step((k == 15) ? UNIT : 64'h0, 1'b0, '0, '0);
    end_steps();
    wait_pulses(1, "gate_pulse_count");
    check("gate_value", vo_val[0], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
